// File: rtl/l2_types_pkg.sv
// ============================================================================
// l2_types_pkg : shared flush-engine state encoding and line-address helper
// Revision 1.0
// ============================================================================
`default_nettype none

package l2_types_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    WRITE = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } flush_state_t;

  // Line-aligned physical address: {tag, index, zero offset}.
  function automatic logic [31:0] l2_line_addr(
    input logic [31:0] tag,
    input logic [31:0] index,
    input int unsigned s_index,
    input int unsigned s_offset
  );
    return (tag << (s_index + s_offset)) | (index << s_offset);
  endfunction

endpackage

`default_nettype wire

// File: rtl/l2_set_way_counter.sv
// ============================================================================
// l2_set_way_counter : set/way walk position, way-major within each set
// Revision 1.0
// ============================================================================
`default_nettype none

module l2_set_way_counter #(
  parameter int SET_W    = 3,
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  output logic [SET_W-1:0] o_set,
  output logic [WAY_W-1:0] o_way,
  output logic             o_last
);

  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             w_last_way;
  logic             w_last_set;

  assign w_last_way = (way_q == WAY_W'(NUM_WAYS - 1));
  assign w_last_set = (set_q == {SET_W{1'b1}});

  // Stepping past the final entry wraps both counters back to zero.
  always_comb begin
    set_d = set_q;
    way_d = way_q;
    if (i_advance) begin
      if (w_last_way) begin
        way_d = '0;
        set_d = set_q + 1'b1;
      end else begin
        way_d = way_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q <= '0;
      way_q <= '0;
    end else begin
      set_q <= set_d;
      way_q <= way_d;
    end
  end

  assign o_set  = set_q;
  assign o_way  = way_q;
  assign o_last = w_last_set & w_last_way;

endmodule

`default_nettype wire

// File: rtl/l2_flush_engine.sv
// ============================================================================
// l2_flush_engine : walks every L2 set/way, writes back valid+dirty lines
// Revision 1.0
// ============================================================================
`default_nettype none

module l2_flush_engine
  import l2_types_pkg::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_OFFSET - S_INDEX,
  parameter int WIDTH    = 256,
  parameter int NUM_WAYS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_req,
  output logic                      flush_busy,
  output logic                      flush_done,
  output logic [S_INDEX-1:0]        arr_index,
  output logic                      arr_read,
  input  logic [NUM_WAYS-1:0]       valid_out,
  input  logic [NUM_WAYS-1:0]       dirty_out,
  input  logic [NUM_WAYS*S_TAG-1:0] tag_out,
  input  logic [NUM_WAYS*WIDTH-1:0] data_out,
  output logic [NUM_WAYS-1:0]       dirty_load,
  output logic                      dirty_datain,
  output logic [31:0]               pmem_address,
  output logic [WIDTH-1:0]          pmem_wdata,
  output logic                      pmem_write,
  input  logic                      pmem_resp
);

  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  generate
    if (S_TAG + S_INDEX + S_OFFSET != 32) begin : g_bad_addr_split
      $error("l2_flush_engine: tag+index+offset bits must equal 32");
    end
    if (WIDTH != 8 * (2 ** S_OFFSET)) begin : g_bad_line_width
      $error("l2_flush_engine: WIDTH must equal 8*2**S_OFFSET");
    end
  endgenerate

  flush_state_t          state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  write_q, write_d;
  logic [NUM_WAYS-1:0]   load_q, load_d;
  logic [31:0]           addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;

  logic [S_INDEX-1:0]    w_set;
  logic [WAY_W-1:0]      w_way;
  logic                  w_last;
  logic                  w_advance;
  logic                  w_valid;
  logic                  w_dirty;
  logic [S_TAG-1:0]      w_tag;
  logic [WIDTH-1:0]      w_data;
  logic [NUM_WAYS-1:0]   w_way_onehot;

  l2_set_way_counter #(
    .SET_W    (S_INDEX),
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (w_advance),
    .o_set     (w_set),
    .o_way     (w_way),
    .o_last    (w_last)
  );

  // Select the current way's array outputs; arrays already follow arr_index.
  always_comb begin
    w_valid      = 1'b0;
    w_dirty      = 1'b0;
    w_tag        = '0;
    w_data       = '0;
    w_way_onehot = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (w_way == WAY_W'(w)) begin
        w_valid         = valid_out[w];
        w_dirty         = dirty_out[w];
        w_tag           = tag_out[w*S_TAG +: S_TAG];
        w_data          = data_out[w*WIDTH +: WIDTH];
        w_way_onehot[w] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    w_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) state_d = SCAN;
      end
      SCAN: begin
        if (w_valid && w_dirty) begin
          state_d = WRITE;
          addr_d  = l2_line_addr(32'(w_tag), 32'(w_set), S_INDEX, S_OFFSET);
          wdata_d = w_data;
        end else begin
          w_advance = 1'b1;
          state_d   = w_last ? DONE : SCAN;
        end
      end
      WRITE: begin
        if (pmem_resp) state_d = CLEAR;
      end
      CLEAR: begin
        w_advance = 1'b1;
        state_d   = w_last ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_d  = (state_d == SCAN) || (state_d == WRITE) || (state_d == CLEAR);
    done_d  = (state_d == DONE);
    write_d = (state_d == WRITE);
    load_d  = (state_d == CLEAR) ? w_way_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      write_q <= 1'b0;
      load_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      write_q <= write_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign flush_busy   = busy_q;
  assign flush_done   = done_q;
  assign arr_index    = w_set;
  assign arr_read     = busy_q;
  assign dirty_load   = load_q;
  assign dirty_datain = 1'b0;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_write   = write_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_flush_engine.sv
// ============================================================================
// tb_l2_flush_engine : directed self-checking bench for l2_flush_engine
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_l2_flush_engine;

  localparam int NS = 8;
  localparam int NW = 2;
  localparam int TW = 24;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           flush_req;
  logic           flush_busy, flush_done, arr_read, dirty_datain, pmem_write;
  logic [2:0]     arr_index;
  logic [NW-1:0]  valid_out, dirty_out, dirty_load;
  logic [NW*TW-1:0] tag_out;
  logic [NW*DW-1:0] data_out;
  logic [31:0]    pmem_address;
  logic [DW-1:0]  pmem_wdata;
  logic           pmem_resp;

  l2_flush_engine dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .arr_index(arr_index), .arr_read(arr_read),
    .valid_out(valid_out), .dirty_out(dirty_out), .tag_out(tag_out), .data_out(data_out),
    .dirty_load(dirty_load), .dirty_datain(dirty_datain), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
  );

  // Single-way build, all lines clean.
  logic           flush_req1, busy1, done1, read1, datain1, write1;
  logic [2:0]     index1;
  logic [0:0]     load1;
  logic [0:0]     zero_v1 = 1'b0;
  logic [TW-1:0]  zero_t1 = '0;
  logic [DW-1:0]  zero_d1 = '0;
  logic [31:0]    addr1;
  logic [DW-1:0]  wdata1;
  logic           resp1 = 1'b0;

  l2_flush_engine #(.NUM_WAYS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req1), .flush_busy(busy1),
    .flush_done(done1), .arr_index(index1), .arr_read(read1),
    .valid_out(zero_v1), .dirty_out(zero_v1), .tag_out(zero_t1), .data_out(zero_d1),
    .dirty_load(load1), .dirty_datain(datain1), .pmem_address(addr1),
    .pmem_wdata(wdata1), .pmem_write(write1), .pmem_resp(resp1)
  );

  // Array model: combinational read at arr_index, dirty write on strobe.
  logic            mem_v [NS][NW];
  logic            mem_d [NS][NW];
  logic [TW-1:0]   mem_t [NS][NW];
  logic [DW-1:0]   mem_l [NS][NW];

  always_comb begin
    valid_out = '0;
    dirty_out = '0;
    tag_out   = '0;
    data_out  = '0;
    for (int w = 0; w < NW; w++) begin
      valid_out[w]           = mem_v[arr_index][w];
      dirty_out[w]           = mem_d[arr_index][w];
      tag_out[w*TW +: TW]    = mem_t[arr_index][w];
      data_out[w*DW +: DW]   = mem_l[arr_index][w];
    end
  end

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++)
      if (dirty_load[w]) mem_d[arr_index][w] <= dirty_datain;
  end

  int checks = 0;
  int errors = 0;

  int r_done, r_busy, r_first_idx, r_stable_err, r_post, r_rd_err;
  logic [31:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int ld_q [$];

  localparam logic [DW-1:0] LINE_A = {4{64'h0123456789ABCDEF}};

  task automatic set_entry(input int s, input int w, input logic v, input logic d,
                           input logic [TW-1:0] t, input logic [DW-1:0] l);
    mem_v[s][w] <= v;
    mem_d[s][w] <= d;
    mem_t[s][w] <= t;
    mem_l[s][w] <= l;
  endtask

  task automatic clear_all();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        set_entry(s, w, 1'b0, 1'b0, '0, '0);
  endtask

  // Issue one request and service memory; lat = WRITE cycles up to and including resp.
  task automatic run_flush(input int lat, input int req_pulse_at, input int resp_pulse_at);
    int wcnt;
    wr_addr.delete(); wr_data.delete(); ld_q.delete();
    r_done = 0; r_busy = 0; r_stable_err = 0; r_first_idx = -1; r_post = 0; r_rd_err = 0;
    wcnt = 0;
    @(posedge clk); #1 flush_req = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      flush_req = 1'b0;
      pmem_resp = 1'b0;
      if (c == 1) r_first_idx = int'(arr_index);
      if (flush_busy) r_busy++;
      if (arr_read !== flush_busy) r_rd_err++;
      if (pmem_write) begin
        wcnt++;
        if (wcnt == 1) begin
          wr_addr.push_back(pmem_address);
          wr_data.push_back(pmem_wdata);
        end else if (pmem_address !== wr_addr[$] || pmem_wdata !== wr_data[$]) begin
          r_stable_err++;
        end
        if (wcnt == lat) pmem_resp = 1'b1;
      end else begin
        wcnt = 0;
      end
      for (int w = 0; w < NW; w++)
        if (dirty_load[w]) ld_q.push_back(int'(arr_index) * NW + w);
      if (c == req_pulse_at) flush_req = 1'b1;
      if (c == resp_pulse_at) pmem_resp = 1'b1;
      if (flush_done) begin
        r_done = c;
        break;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (flush_done || flush_busy) r_post++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_req = 1'b0; flush_req1 = 1'b0; pmem_resp = 1'b0;
    clear_all();
    #12;
    checks++;
    if ({flush_busy, flush_done, pmem_write, arr_read, dirty_datain} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000",
                         {flush_busy, flush_done, pmem_write, arr_read, dirty_datain});
    end
    checks++;
    if (pmem_address !== 32'h0 || arr_index !== 3'd0 || dirty_load !== 2'b00) begin
      errors++; $display("FAIL reset_addr: addr %h idx %0d load %b expected 0/0/00",
                         pmem_address, arr_index, dirty_load);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_all_clean();
    clear_all();
    run_flush(1, 0, 0);
    checks++;
    if (r_done !== 17) begin errors++; $display("FAIL clean_done_cycle: got %0d expected 17", r_done); end
    checks++;
    if (r_busy !== 16) begin errors++; $display("FAIL clean_busy_cycles: got %0d expected 16", r_busy); end
    checks++;
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL clean_writes: got %0d expected 0", wr_addr.size()); end
    checks++;
    if (r_post !== 0 || r_first_idx !== 0 || r_rd_err !== 0) begin
      errors++; $display("FAIL clean_misc: post %0d first_idx %0d rd_err %0d expected 0/0/0",
                         r_post, r_first_idx, r_rd_err);
    end
  endtask

  task automatic test_single_dirty();
    clear_all();
    set_entry(3, 1, 1'b1, 1'b1, 24'hABCDEF, LINE_A);
    set_entry(3, 0, 1'b1, 1'b0, 24'h123456, ~LINE_A);
    run_flush(4, 0, 0);
    checks++;
    if (r_done !== 22) begin errors++; $display("FAIL single_done_cycle: got %0d expected 22", r_done); end
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 32'hABCDEF60) begin
      errors++; $display("FAIL single_addr: got n=%0d addr %h expected n=1 abcdef60",
                         wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'h0);
    end
    checks++;
    if (wr_data.size() !== 1 || wr_data[0] !== LINE_A || r_stable_err !== 0) begin
      errors++; $display("FAIL single_wdata: got n=%0d unstable %0d expected n=1 matching line",
                         wr_data.size(), r_stable_err);
    end
    checks++;
    if (ld_q.size() !== 1 || ld_q[0] !== 7 || mem_d[3][1] !== 1'b0) begin
      errors++; $display("FAIL single_clear: got %0d strobes first %0d dirty %b expected 1 at entry 7, dirty 0",
                         ld_q.size(), (ld_q.size() > 0) ? ld_q[0] : -1, mem_d[3][1]);
    end
  endtask

  task automatic test_all_dirty();
    int bad_wr, bad_ld, bad_bit;
    logic [31:0] ea;
    logic [DW-1:0] ed;
    clear_all();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        set_entry(s, w, 1'b1, 1'b1, 24'(256 + s*NW + w), {8{32'hA5A50000 | 32'(s*NW + w)}});
    run_flush(1, 0, 0);
    checks++;
    if (r_done !== 49) begin errors++; $display("FAIL dirty_done_cycle: got %0d expected 49", r_done); end
    checks++;
    if (wr_addr.size() !== 16 || ld_q.size() !== 16) begin
      errors++; $display("FAIL dirty_counts: got %0d writes %0d strobes expected 16/16",
                         wr_addr.size(), ld_q.size());
    end
    bad_wr = 0; bad_ld = 0; bad_bit = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      ea = {24'(256 + i), 3'(i / NW), 5'b0};
      ed = {8{32'hA5A50000 | 32'(i)}};
      if (wr_addr[i] !== ea || wr_data[i] !== ed) bad_wr++;
    end
    for (int i = 0; i < ld_q.size(); i++) if (ld_q[i] !== i) bad_ld++;
    for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) if (mem_d[s][w] !== 1'b0) bad_bit++;
    checks++;
    if (bad_wr !== 0) begin errors++; $display("FAIL dirty_order: got %0d bad writes expected 0", bad_wr); end
    checks++;
    if (bad_ld !== 0 || bad_bit !== 0) begin
      errors++; $display("FAIL dirty_strobes: got %0d misordered %0d still dirty expected 0/0", bad_ld, bad_bit);
    end
  endtask

  task automatic test_spurious();
    clear_all();
    set_entry(3, 1, 1'b1, 1'b1, 24'hABCDEF, LINE_A);
    run_flush(2, 5, 8);
    checks++;
    if (r_done !== 20) begin errors++; $display("FAIL spurious_done_cycle: got %0d expected 20", r_done); end
    checks++;
    if (wr_addr.size() !== 1 || ld_q.size() !== 1 || r_post !== 0) begin
      errors++; $display("FAIL spurious_effects: got writes %0d strobes %0d post %0d expected 1/1/0",
                         wr_addr.size(), ld_q.size(), r_post);
    end
  endtask

  task automatic test_reset_mid_write();
    clear_all();
    set_entry(3, 1, 1'b1, 1'b1, 24'hABCDEF, LINE_A);
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pmem_write) break;
      @(posedge clk); #1;
    end
    checks++;
    if (pmem_write !== 1'b1) begin errors++; $display("FAIL rst_reach_write: got %b expected 1", pmem_write); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pmem_write, flush_busy, flush_done, arr_read} !== 4'b0 || pmem_address !== 32'h0 ||
        pmem_wdata !== '0 || arr_index !== 3'd0 || dirty_load !== 2'b00) begin
      errors++; $display("FAIL rst_outputs: got wr %b busy %b addr %h idx %0d expected all 0",
                         pmem_write, flush_busy, pmem_address, arr_index);
    end
    checks++;
    if (mem_d[3][1] !== 1'b1) begin errors++; $display("FAIL rst_dirty_kept: got %b expected 1", mem_d[3][1]); end
    @(posedge clk); #1 rst_n = 1'b1;
    run_flush(1, 0, 0);
    checks++;
    if (r_first_idx !== 0 || r_done !== 19 || wr_addr.size() !== 1 || wr_addr[0] !== 32'hABCDEF60) begin
      errors++; $display("FAIL rst_restart: got idx %0d done %0d writes %0d expected 0/19/1",
                         r_first_idx, r_done, wr_addr.size());
    end
  endtask

  task automatic test_invalid_dirty();
    clear_all();
    set_entry(2, 0, 1'b0, 1'b1, 24'h000055, LINE_A);
    run_flush(1, 0, 0);
    checks++;
    if (r_done !== 17 || wr_addr.size() !== 0 || mem_d[2][0] !== 1'b1) begin
      errors++; $display("FAIL invalid_dirty: got done %0d writes %0d dirty %b expected 17/0/1",
                         r_done, wr_addr.size(), mem_d[2][0]);
    end
  endtask

  task automatic test_back_to_back();
    int d1, b2, d2, late;
    d1 = 0; b2 = 0; d2 = 0; late = 0;
    clear_all();
    @(posedge clk); #1 flush_req = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 20) flush_req = 1'b0;
      if (flush_done && d1 == 0) d1 = c;
      else if (flush_done && d2 == 0) d2 = c;
      if (d1 != 0 && b2 == 0 && flush_busy) b2 = c;
      if (d2 != 0 && c > d2 && (flush_busy || flush_done)) late++;
    end
    checks++;
    if (d1 !== 17 || b2 !== 19) begin
      errors++; $display("FAIL held_req_restart: got done %0d rebusy %0d expected 17/19", d1, b2);
    end
    checks++;
    if (d2 !== 35 || late !== 0) begin
      errors++; $display("FAIL held_req_second: got done %0d late %0d expected 35/0", d2, late);
    end
  endtask

  task automatic test_one_way();
    int busy_n, done_at, wr_n;
    busy_n = 0; done_at = 0; wr_n = 0;
    @(posedge clk); #1 flush_req1 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      flush_req1 = 1'b0;
      if (busy1) busy_n++;
      if (write1) wr_n++;
      if (done1) begin done_at = c; break; end
    end
    checks++;
    if (busy_n !== 8 || done_at !== 9 || wr_n !== 0) begin
      errors++; $display("FAIL one_way: got busy %0d done %0d writes %0d expected 8/9/0", busy_n, done_at, wr_n);
    end
  endtask

  initial begin
    test_reset();
    test_all_clean();
    test_single_dirty();
    test_all_dirty();
    test_spurious();
    test_reset_mid_write();
    test_invalid_dirty();
    test_back_to_back();
    test_one_way();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
